// File: rtl/bcd_conv_sequencer.sv
// bcd_conv_sequencer
//   Control stage for an external 8-bit double-dabble shift-and-add register.
//   It accepts a binary value on a valid/ready handshake and clears the
//   register. It then drives alternating add-3 adjust and shift cycles,
//   MSB first. Finally it captures the register's packed two-digit BCD
//   result and offers it downstream with an overflow flag.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   bin_in, in_valid     binary value to convert and its valid
//   in_ready             high only while idle
//   sr_clr_n             register clear (low clears on next edge)
//   sr_d, sr_en, sr_adda serial data, shift enable, add-3 enable to register
//   sr_out               register parallel output {tens, units}
//   bcd_out, ovf         captured BCD result and "input >= OVF_LIMIT" flag
//   out_valid, out_ready downstream handshake
//   busy                 high whenever not idle
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for in_valid; in_ready high
// S_CLEAR   | register cleared via sr_clr_n for one cycle
// S_ADJ     | register add-3 adjust (sr_adda)
// S_SHIFT   | register shift of one input bit, MSB first (sr_en)
// S_CAPTURE | sr_out sampled into bcd_out, out_valid set
// S_DONE    | result held until out_ready

module bcd_conv_sequencer #(
  parameter int WIDTH     = 8,
  parameter int OVF_LIMIT = 100
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sr_clr_n,
  output logic             sr_d,
  output logic             sr_en,
  output logic             sr_adda,
  input  logic [7:0]       sr_out,
  output logic [7:0]       bcd_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [31:0]     OVF_LIM  = 32'(OVF_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ADJ,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;
  logic             clr_req;

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    sr_en     = 1'b0;
    sr_adda   = 1'b0;
    sr_d      = 1'b0;
    clr_req   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        clr_req   = 1'b1;
        state_nxt = S_ADJ;
      end
      // The first adjust acts on a cleared register and does nothing;
      // it is kept so that every bit sees the same adjust/shift pair.
      S_ADJ: begin
        sr_adda   = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        sr_en     = 1'b1;
        sr_d      = shreg[WIDTH-1];
        state_nxt = (cnt == '0) ? S_CAPTURE : S_ADJ;
      end
      S_CAPTURE: state_nxt = S_CAPTURE == state ? S_DONE : S_IDLE;
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Reset is folded in so that the register is also held clear whenever
  // this block is in reset, and no stale digits survive an abort.
  assign sr_clr_n = rstn & ~clr_req;
  assign busy     = ~in_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg     <= '0;
      cnt       <= '0;
      ovf_pend  <= 1'b0;
      bcd_out   <= 8'h00;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg    <= bin_in;
            ovf_pend <= (32'(bin_in) >= OVF_LIM);
            cnt      <= CNT_LOAD;
          end
        end
        S_SHIFT: begin
          shreg <= shreg << 1;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        S_CAPTURE: begin
          bcd_out   <= sr_out;
          ovf       <= ovf_pend;
          out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sequencer.sv
// Bench for bcd_conv_sequencer.
//   Contains a behavioural double-dabble register driving sr_out.
//   A reference model describes each conversion by its accept edge and
//   the number of cycles elapsed since then.
//   A single monitor compares every DUT output against that model on
//   each falling edge.
//   Directed conversions additionally pin literal results.
module tb_bcd_conv_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] bin_in;
  logic         in_valid;
  logic         in_ready;
  logic         sr_clr_n;
  logic         sr_d;
  logic         sr_en;
  logic         sr_adda;
  logic [7:0]   sr_out;
  logic [7:0]   bcd_out;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  bcd_conv_sequencer #(.WIDTH(W), .OVF_LIMIT(100)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bin_in    (bin_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sr_clr_n  (sr_clr_n),
    .sr_d      (sr_d),
    .sr_en     (sr_en),
    .sr_adda   (sr_adda),
    .sr_out    (sr_out),
    .bcd_out   (bcd_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural shift-and-add register (two BCD digits, hundreds dropped).
  logic [7:0] sreg = 8'h00;
  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
  always @(posedge clk) begin
    if (!sr_clr_n)    sreg <= 8'h00;
    else if (sr_adda) sreg <= {adj(sreg[7:4]), adj(sreg[3:0])};
    else if (sr_en)   sreg <= {sreg[6:0], sr_d};
  end
  assign sr_out = sreg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd_of(input int v);
    int m;
    m = v % 100;
    return 8'(((m / 10) * 16) + (m % 10));
  endfunction

  // Reference model / monitor
  bit         started = 0;
  bit         pend    = 0;
  bit         rst_prev = 0;
  int         cyc     = 0;
  int         acc_cyc = 0;
  logic [7:0] pv      = 8'h00;

  initial begin
    int   k;
    bit   e_clr, e_adda, e_en, e_ov, s_rstn, s_acc, s_hs;
    logic [7:0] s_bin;
    forever begin
      @(negedge clk);
      k      = cyc - acc_cyc;
      e_clr  = rstn && !(pend && k == 0);
      e_adda = pend && k >= 1 && k <= 2*W-1 && (k % 2) == 1;
      e_en   = pend && k >= 2 && k <= 2*W   && (k % 2) == 0;
      e_ov   = pend && k >= 2*W+2;
      if (started) begin
        if (rst_prev) begin
          chk("reset_out_valid", out_valid, 0);
          chk("reset_bcd_out",   bcd_out,   0);
          chk("reset_ovf",       ovf,       0);
        end
        chk("sr_clr_n",  sr_clr_n,  e_clr);
        chk("sr_adda",   sr_adda,   e_adda);
        chk("sr_en",     sr_en,     e_en);
        if (e_en) chk("sr_d", sr_d, pv[W - k/2]);
        chk("in_ready",  in_ready,  !pend);
        chk("busy",      busy,      pend);
        chk("out_valid", out_valid, e_ov);
        if (e_ov) begin
          chk("bcd_out", bcd_out, bcd_of(int'(pv)));
          chk("ovf",     ovf,     pv >= 8'd100);
        end
      end
      s_rstn = rstn;
      s_acc  = rstn && in_valid && !pend;
      s_hs   = rstn && e_ov && out_ready;
      s_bin  = bin_in;
      @(posedge clk);
      cyc++;
      if (!s_rstn) begin
        pend    = 0;
        started = 1;
      end else begin
        if (s_hs) begin
          pend = 0;
          n_done++;
        end
        if (s_acc) begin
          pend    = 1;
          acc_cyc = cyc;
          pv      = s_bin;
        end
      end
      rst_prev = !s_rstn;
    end
  end

  // Stimulus helpers (drive 1 time unit after the rising edge)
  task automatic start(input logic [7:0] v);
    int t;
    bin_in   = v;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int t;
    t = 0;
    while (!out_valid && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic convert(input logic [7:0] v, input logic [7:0] exp_b,
                         input logic exp_o, input int hold, input bit poke);
    start(v);
    wait_ov();
    chk("lit_bcd", bcd_out, exp_b);
    chk("lit_ovf", ovf, exp_o);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = (i % 2) == 0;
        bin_in   = 8'($urandom);
      end
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready",  in_ready,  0);
      chk("bp_bcd_hold",  bcd_out,   exp_b);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready",  in_ready,  1);
  endtask

  initial begin
    int n;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clr_n_low", sr_clr_n, 0);
    chk("rst_in_ready",  in_ready, 1);
    rstn = 1'b1;
    @(posedge clk); #1;

    convert(8'd42,  8'h42, 1'b0, 0, 0);
    convert(8'd0,   8'h00, 1'b0, 0, 0);
    convert(8'd99,  8'h99, 1'b0, 0, 0);
    convert(8'd255, 8'h55, 1'b1, 0, 0);
    convert(8'd100, 8'h00, 1'b1, 0, 0);
    convert(8'd73,  8'h73, 1'b0, 10, 1);

    // Abort during the 5th shift cycle
    start(8'd200);
    n = 0;
    for (int t = 0; t < 40 && n < 5; t++) begin
      if (sr_en) n++;
      if (n < 5) begin
        @(posedge clk); #1;
      end
    end
    chk("abort_reached_shift5", sr_en, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_bcd_out",   bcd_out,   0);
    chk("abort_in_ready",  in_ready,  1);
    chk("abort_clr_n",     sr_clr_n,  0);
    @(posedge clk); #1;
    rstn = 1'b1;
    convert(8'd37, 8'h37, 1'b0, 0, 0);

    // in_valid held while bin_in wanders during the conversion
    bin_in   = 8'd61;
    in_valid = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 40 && !out_valid; t++) begin
      bin_in = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("held_bcd", bcd_out, 8'h61);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Randomised traffic, including occasional resets
    for (int i = 0; i < 1500; i++) begin
      rstn      = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 1) != 0);
      bin_in    = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    rstn      = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("enough_conversions", n_done >= 40, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
